// File: rtl/sha256_block_sequencer_pkg.sv
// sha256_seq_pkg: shared state type, block constants and padded block-count helper
// for the SHA-256 block sequencer.
package sha256_seq_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_READ, S_WAIT, S_EMIT, S_DONE} seq_state_t;
    localparam int BLOCK_WORDS = 16;
    localparam logic [31:0] MAX_SIZE = 32'd4194231;
    // Message + 0x80 marker + 8 length bytes, rounded up to whole 64-byte blocks.
    function automatic logic [32:0] calc_blocks(input logic [31:0] size);
        return ({1'b0, size} + 33'd72) >> 6;
    endfunction
endpackage

// File: rtl/sha256_block_sequencer_if.sv
// sha256_block_sequencer_if: message memory read port and padded word stream to the hash core.
interface sha256_block_sequencer_if #(parameter int ADDR_W = 16);
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_read_data;
    logic              blk_valid;
    logic              blk_ready;
    logic [31:0]       blk_word;
    logic [3:0]        blk_idx;
    logic [15:0]       blk_num;
    logic              blk_first;
    logic              blk_last;
    modport master (
        output mem_re, mem_addr, blk_valid, blk_word, blk_idx, blk_num, blk_first, blk_last,
        input  mem_read_data, blk_ready
    );
    modport slave (
        input  mem_re, mem_addr, blk_valid, blk_word, blk_idx, blk_num, blk_first, blk_last,
        output mem_read_data, blk_ready
    );
endinterface

// File: rtl/sha256_block_sequencer_pad_word.sv
// sha256_pad_word: builds padded word g of a message of size bytes from a raw memory word,
// masking bytes past the message, inserting the 0x80 marker and the 64-bit bit length.
module sha256_pad_word (
    input  logic [19:0] g,
    input  logic [31:0] size,
    input  logic [19:0] t,
    input  logic [31:0] raw,
    output logic [31:0] word
);
    logic [31:0] pad;
    for (genvar i = 0; i < 4; i++) begin : g_byte
        logic [31:0] b;
        assign b = 32'({g, 2'(i)});
        assign pad[31-8*i -: 8] = b < size ? raw[31-8*i -: 8] : b == size ? 8'h80 : 8'h00;
    end
    assign word = g == t - 20'd2 ? size >> 29 : g == t - 20'd1 ? size << 3 : pad;
endmodule

// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: fetches one message from word memory and streams it to the
// compression core as SHA-256 padded 512-bit blocks, one tagged word per handshake.
module sha256_block_sequencer
    import sha256_seq_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          message_addr,
    input  logic [31:0]                size,
    output logic [15:0]                num_blocks,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    sha256_block_sequencer_if.master   bus
);
    seq_state_t        state_q, state_d;
    logic [31:0]       size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       nb_q;
    logic [19:0]       g_q, g_next, t, pad_g;
    logic [31:0]       word_q, pad_word;
    logic [32:0]       nb_calc;
    logic              legal, xfer, last, need_mem;

    assign nb_calc  = calc_blocks(size_q);
    // A block count that fits 16 bits is exactly the legal size range.
    assign legal    = nb_calc[32:16] == '0;
    assign t        = 20'(state_q == S_CALC ? nb_calc[15:0] : nb_q) * 20'(BLOCK_WORDS);
    assign g_next   = g_q + 20'd1;
    assign xfer     = state_q == S_EMIT && bus.blk_ready;
    assign last     = g_q == t - 20'd1;
    assign need_mem = 32'({g_next, 2'b00}) < size_q;
    assign pad_g    = state_q == S_EMIT ? g_next : g_q;

    sha256_pad_word u_pad (
        .g    (pad_g),
        .size (size_q),
        .t    (t),
        .raw  (state_q == S_WAIT ? bus.mem_read_data : 32'd0),
        .word (pad_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_CALC : S_IDLE;
            S_CALC:  state_d = !legal ? S_IDLE : size_q != '0 ? S_READ : S_EMIT;
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_EMIT;
            S_EMIT:  state_d = !xfer ? S_EMIT : last ? S_DONE : need_mem ? S_READ : S_EMIT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            size_q  <= '0;
            addr_q  <= '0;
            nb_q    <= '0;
            g_q     <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                size_q <= size;
                addr_q <= message_addr;
                g_q    <= '0;
            end
            if (state_q == S_CALC)
                nb_q <= legal ? nb_calc[15:0] : '0;
            if (state_q == S_CALC || state_q == S_WAIT || xfer)
                word_q <= pad_word;
            if (xfer)
                g_q <= g_next;
        end
    end

    assign bus.mem_re    = state_q == S_READ;
    assign bus.mem_addr  = addr_q + ADDR_W'(g_q);
    assign bus.blk_valid = state_q == S_EMIT;
    assign bus.blk_word  = word_q;
    assign bus.blk_idx   = g_q[3:0];
    assign bus.blk_num   = g_q[19:4];
    assign bus.blk_first = state_q == S_EMIT && g_q == '0;
    assign bus.blk_last  = state_q == S_EMIT && last;
    assign num_blocks    = nb_q;
    assign busy          = state_q != S_IDLE;
    assign done          = state_q == S_DONE;
    assign err           = state_q == S_CALC && !legal;
endmodule
